// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: runs each 32-bit load/store as two
// 16-bit SRAM accesses (low half first) while the pipeline is frozen.
module mem_stage_sram_ctrl #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned SRAM_ADDR_W = 18,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   MEM_R_EN_in,
   input  logic                   MEM_W_EN_in,
   input  logic [31:0]            ALU_result_in,
   input  logic [31:0]            ST_val_in,
   output logic                   freeze,
   output logic                   ready,
   output logic [31:0]            read_data,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
);

   localparam int unsigned AW = SRAM_ADDR_W - 1;
   localparam int unsigned CW =
      (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LP_CNT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [AW-1:0]         r_word;
   logic [31:0]           r_st;
   logic                  r_ld;
   logic [15:0]           r_rd_lo;
   logic [31:0]           r_read_data;
   logic                  r_ready;
   logic [SRAM_ADDR_W-1:0] r_sram_addr;
   logic [15:0]           r_dq_out;
   logic                  r_dq_oe;
   logic                  r_we_n;
   logic                  r_oe_n;

   logic                  w_req;
   logic [AW-1:0]         w_word;

   assign w_req  = MEM_R_EN_in | MEM_W_EN_in;
   assign w_word = AW'((ALU_result_in - 32'(ADDR_BASE)) >> 2);

   // Access sequencer; SRAM pins are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_word      <= '0;
         r_st        <= '0;
         r_ld        <= 1'b0;
         r_rd_lo     <= '0;
         r_read_data <= '0;
         r_ready     <= 1'b0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_word      <= w_word;
                  r_st        <= ST_val_in;
                  r_ld        <= MEM_R_EN_in;
                  r_cnt       <= LP_CNT;
                  r_state     <= S_LO;
                  r_sram_addr <= {w_word, 1'b0};
                  if (MEM_R_EN_in) begin
                     r_oe_n <= 1'b0;
                  end else begin
                     r_we_n   <= 1'b0;
                     r_dq_oe  <= 1'b1;
                     r_dq_out <= ST_val_in[15:0];
                  end
               end
            end
            S_LO: begin
               if (r_cnt == '0) begin
                  if (r_ld) r_rd_lo <= sram_dq_in;
                  r_cnt       <= LP_CNT;
                  r_state     <= S_HI;
                  r_sram_addr <= {r_word, 1'b1};
                  r_dq_out    <= r_st[31:16];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HI: begin
               if (r_cnt == '0) begin
                  if (r_ld) r_read_data <= {sram_dq_in, r_rd_lo};
                  r_state     <= S_DONE;
                  r_ready     <= 1'b1;
                  r_sram_addr <= '0;
                  r_dq_out    <= '0;
                  r_dq_oe     <= 1'b0;
                  r_we_n      <= 1'b1;
                  r_oe_n      <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_ready <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stall upstream from request acceptance until the access is done.
   always_comb begin
      freeze = rst & (((r_state == S_IDLE) & w_req) |
                      (r_state == S_LO) | (r_state == S_HI));
   end

   assign ready       = r_ready;
   assign read_data   = r_read_data;
   assign sram_addr   = r_sram_addr;
   assign sram_dq_out = r_dq_out;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_we_n   = r_we_n;
   assign sram_oe_n   = r_oe_n;

endmodule
